// File: rtl/sgd_train_sched.sv
// Training sequencer for the SGD datapath: arbitrates one single-port dataset RAM
// between the host loader and the run, streams words to the datapath, writes back weights.
module sgd_train_sched #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            feat,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic [7:0]            epoch,
  input  logic [3:0]            learn_rate,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  dp_valid,
  output logic                  dp_wload,
  output logic [DATA_WIDTH-1:0] dp_data,
  input  logic                  dp_ready,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic [3:0]            cfg_feat,
  output logic [3:0]            cfg_lr,
  output logic [7:0]            epoch_cnt,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_PRES = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] dp_cnt_q, dp_cnt_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [7:0]            e_q, e_d;
  logic [7:0]            epoch_cnt_q, epoch_cnt_d;
  logic [3:0]            feat_q, feat_d;
  logic [3:0]            lr_q, lr_d;
  logic [DATA_WIDTH-1:0] dp_data_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      dp_cnt_q    <= '0;
      n_q         <= '0;
      e_q         <= '0;
      epoch_cnt_q <= '0;
      feat_q      <= '0;
      lr_q        <= '0;
      dp_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      dp_cnt_q    <= dp_cnt_d;
      n_q         <= n_d;
      e_q         <= e_d;
      epoch_cnt_q <= epoch_cnt_d;
      feat_q      <= feat_d;
      lr_q        <= lr_d;
      if (state_q == S_LAT) dp_data_q <= ram_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    dp_cnt_d    = dp_cnt_q;
    n_d         = n_q;
    e_d         = e_q;
    epoch_cnt_d = epoch_cnt_q;
    feat_d      = feat_q;
    lr_d        = lr_q;
    host_gnt    = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    dp_valid    = 1'b0;
    dp_wload    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        host_gnt = host_req & ~start;
        if (host_gnt) begin
          ram_en    = 1'b1;
          ram_we    = host_we;
          ram_addr  = host_addr;
          ram_wdata = host_wdata;
        end
        if (start) begin
          n_d         = data_points;
          e_d         = epoch;
          feat_d      = feat;
          lr_d        = learn_rate;
          dp_cnt_d    = '0;
          epoch_cnt_d = '0;
          state_d     = (data_points == '0 || epoch == 8'd0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        ram_en   = 1'b1;
        ram_addr = dp_cnt_q;
        state_d  = S_LAT;
      end
      S_LAT: state_d = S_PRES;
      S_PRES: begin
        dp_valid = 1'b1;
        dp_wload = (dp_cnt_q == '0);
        if (dp_ready) begin
          if (dp_cnt_q < n_q) begin
            dp_cnt_d = dp_cnt_q + 1'b1;
            state_d  = S_RD;
          end else begin
            // end of epoch: later epochs skip the weight word at addr 0
            epoch_cnt_d = epoch_cnt_q + 8'd1;
            dp_cnt_d    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            state_d     = (epoch_cnt_q + 8'd1 == e_q) ? S_WB : S_RD;
          end
        end
      end
      S_WB: begin
        ram_en    = ~abort;
        ram_we    = ~abort;
        ram_addr  = n_q + 1'b1;
        ram_wdata = w_in;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = ~abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      dp_cnt_d    = dp_cnt_q;
      epoch_cnt_d = epoch_cnt_q;
    end
  end

  assign host_rdata = ram_rdata;
  assign dp_data    = dp_data_q;
  assign cfg_feat   = feat_q;
  assign cfg_lr     = lr_q;
  assign epoch_cnt  = epoch_cnt_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sgd_train_sched.sv
// Directed bench for sgd_train_sched with a behavioural 1-cycle-latency RAM and event log.
module tb_sgd_train_sched;
  localparam int AW = 12;
  localparam int DW = 256;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    feat = '0;
  logic [AW-1:0] data_points = '0;
  logic [7:0]    epoch = '0;
  logic [3:0]    learn_rate = '0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          dp_valid, dp_wload;
  logic [DW-1:0] dp_data;
  logic          dp_ready = 1'b0;
  logic [DW-1:0] w_in = '0;
  logic [3:0]    cfg_feat, cfg_lr;
  logic [7:0]    epoch_cnt;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  sgd_train_sched dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .feat(feat),
    .data_points(data_points), .epoch(epoch), .learn_rate(learn_rate),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dp_valid(dp_valid), .dp_wload(dp_wload), .dp_data(dp_data), .dp_ready(dp_ready),
    .w_in(w_in), .cfg_feat(cfg_feat), .cfg_lr(cfg_lr), .epoch_cnt(epoch_cnt),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Sequencer-side activity only; host-granted accesses are not logged.
  logic          log_clr = 1'b0;
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [DW-1:0] hs_data_q[$];
  bit            hs_wload_q[$];
  int            done_cnt = 0;
  int            ram_en_cnt = 0;

  always @(posedge CLK) begin
    if (log_clr) begin
      rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
      hs_data_q.delete(); hs_wload_q.delete();
      done_cnt <= 0; ram_en_cnt <= 0;
    end else begin
      if (ram_en && !host_gnt) ram_en_cnt <= ram_en_cnt + 1;
      if (ram_en && !ram_we && !host_gnt) rd_q.push_back(ram_addr);
      if (ram_en && ram_we && !host_gnt) begin
        wr_addr_q.push_back(ram_addr);
        wr_data_q.push_back(ram_wdata);
      end
      if (dp_valid && dp_ready && !abort) begin
        hs_data_q.push_back(dp_data);
        hs_wload_q.push_back(dp_wload);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic logic [DW-1:0] word_val(input int i);
    logic [15:0] f;
    f = 16'hA000 + 16'(i);
    return {16{f}};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    step();
    log_clr = 1'b0;
  endtask

  task automatic load_ram();
    for (int i = 0; i < 5; i++) begin
      host_req = 1'b1; host_we = 1'b1;
      host_addr = AW'(i); host_wdata = word_val(i);
      step();
    end
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic start_run(input int n, input int e, input int f, input int lr);
    data_points = AW'(n); epoch = 8'(e); feat = 4'(f); learn_rate = 4'(lr);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (dp_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_valid: got %0b want 0", dp_valid); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %0b want 0", ram_en); end
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_host_gnt: got %0b want 0", host_gnt); end
    checks++; if (epoch_cnt !== 8'd0) begin errors++; $display("FAIL reset_epoch_cnt: got %0d want 0", epoch_cnt); end
    checks++; if (dp_data !== '0) begin errors++; $display("FAIL reset_dp_data: got %0h want 0", dp_data); end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit to;
    int exp_rd[7] = '{0, 1, 2, 3, 1, 2, 3};
    int wl;
    load_ram();
    clear_log();
    dp_ready = 1'b1;
    w_in = {16{16'hC0DE}};
    start_run(3, 2, 5, 3);
    checks++; if (ram_en !== 1'b1 || ram_addr !== AW'(0)) begin errors++; $display("FAIL basic_first_rd: got en=%0b addr=%0d want en=1 addr=0", ram_en, ram_addr); end
    checks++; if (dp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %0b want 0", dp_valid); end
    feat = 4'd9; data_points = AW'(7); epoch = 8'd9; learn_rate = 4'd1;
    step(); step();
    checks++; if (dp_valid !== 1'b1 || dp_wload !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got valid=%0b wload=%0b want 1 1", dp_valid, dp_wload); end
    checks++; if (dp_data !== word_val(0)) begin errors++; $display("FAIL basic_first_data: got %0h want %0h", dp_data, word_val(0)); end
    wait_idle(200, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got busy after 200 cycles want idle"); end
    checks++; if (rd_q.size() !== 7) begin errors++; $display("FAIL basic_rd_count: got %0d want 7", rd_q.size()); end
    checks++; if (hs_data_q.size() !== 7) begin errors++; $display("FAIL basic_hs_count: got %0d want 7", hs_data_q.size()); end
    if (rd_q.size() == 7 && hs_data_q.size() == 7) begin
      wl = 0;
      for (int i = 0; i < 7; i++) begin
        checks++; if (rd_q[i] !== AW'(exp_rd[i])) begin errors++; $display("FAIL basic_rd_addr[%0d]: got %0d want %0d", i, rd_q[i], exp_rd[i]); end
        checks++; if (hs_data_q[i] !== word_val(exp_rd[i])) begin errors++; $display("FAIL basic_hs_data[%0d]: got %0h want %0h", i, hs_data_q[i], word_val(exp_rd[i])); end
        if (hs_wload_q[i]) wl++;
      end
      checks++; if (hs_wload_q[0] !== 1'b1 || wl !== 1) begin errors++; $display("FAIL basic_wload: got first=%0b total=%0d want first=1 total=1", hs_wload_q[0], wl); end
    end
    checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL basic_wb_count: got %0d want 1", wr_addr_q.size()); end
    else begin
      checks++; if (wr_addr_q[0] !== AW'(4)) begin errors++; $display("FAIL basic_wb_addr: got %0d want 4", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== {16{16'hC0DE}}) begin errors++; $display("FAIL basic_wb_data: got %0h want c0de pattern", wr_data_q[0]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (epoch_cnt !== 8'd2) begin errors++; $display("FAIL basic_epoch_cnt: got %0d want 2", epoch_cnt); end
    checks++; if (cfg_feat !== 4'd5 || cfg_lr !== 4'd3) begin errors++; $display("FAIL basic_cfg: got feat=%0d lr=%0d want 5 3", cfg_feat, cfg_lr); end
  endtask

  task automatic test_zero_len();
    int cfg_n[2] = '{3, 0};
    int cfg_e[2] = '{0, 2};
    for (int k = 0; k < 2; k++) begin
      clear_log();
      start_run(cfg_n[k], cfg_e[k], 1, 1);
      checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero%0d_done_pulse: got done=%0b busy=%0b want 1 1", k, done, busy); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero%0d_back_idle: got done=%0b busy=%0b want 0 0", k, done, busy); end
      checks++; if (done_cnt !== 1 || ram_en_cnt !== 0) begin errors++; $display("FAIL zero%0d_no_ram: got done_cnt=%0d ram_en_cnt=%0d want 1 0", k, done_cnt, ram_en_cnt); end
    end
  endtask

  task automatic test_stall();
    bit to;
    int bad;
    logic [DW-1:0] held;
    load_ram();
    clear_log();
    dp_ready = 1'b0;
    w_in = {16{16'h1234}};
    start_run(2, 1, 2, 2);
    step(); step();
    held = dp_data;
    checks++; if (held !== word_val(0)) begin errors++; $display("FAIL stall_data: got %0h want %0h", held, word_val(0)); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (dp_valid !== 1'b1 || dp_wload !== 1'b1 || dp_data !== held || ram_en !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    dp_ready = 1'b1;
    step();
    checks++; if (dp_valid !== 1'b0 || ram_en !== 1'b1 || ram_addr !== AW'(1)) begin errors++; $display("FAIL stall_advance: got valid=%0b en=%0b addr=%0d want 0 1 1", dp_valid, ram_en, ram_addr); end
    wait_idle(100, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: got busy want idle"); end
    checks++; if (rd_q.size() !== 3 || hs_data_q.size() !== 3) begin errors++; $display("FAIL stall_counts: got rd=%0d hs=%0d want 3 3", rd_q.size(), hs_data_q.size()); end
    checks++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== AW'(3)) begin errors++; $display("FAIL stall_wb: got n=%0d addr=%0d want 1 3", wr_addr_q.size(), wr_addr_q[0]); end
  endtask

  task automatic test_abort();
    bit found;
    load_ram();
    clear_log();
    dp_ready = 1'b1;
    start_run(3, 2, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dp_valid && dp_data === word_val(2)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach_dp2: got no PRES of word 2 want it within 30 cycles"); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || dp_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%0b valid=%0b want 0 0", busy, dp_valid); end
    step(); step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got busy=%0b want 0", busy); end
    checks++; if (done_cnt !== 0 || wr_addr_q.size() !== 0) begin errors++; $display("FAIL abort_no_wb_done: got done=%0d writes=%0d want 0 0", done_cnt, wr_addr_q.size()); end
    checks++; if (hs_data_q.size() !== 2 || epoch_cnt !== 8'd0) begin errors++; $display("FAIL abort_progress: got hs=%0d epoch=%0d want 2 0", hs_data_q.size(), epoch_cnt); end
    host_req = 1'b1; host_we = 1'b0; host_addr = AW'(1);
    #1;
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL abort_host_gnt: got %0b want 1", host_gnt); end
    step();
    host_req = 1'b0;
    checks++; if (host_rdata !== word_val(1)) begin errors++; $display("FAIL abort_host_rdata: got %0h want %0h", host_rdata, word_val(1)); end
  endtask

  task automatic test_host_vs_start();
    int gnt_bad;
    bit to;
    clear_log();
    dp_ready = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = AW'(0);
    data_points = AW'(1); epoch = 8'd1;
    start = 1'b1;
    #1;
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL tie_host_gnt: got %0b want 0", host_gnt); end
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tie_run_started: got busy=%0b want 1", busy); end
    gnt_bad = 0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!busy) begin
        to = 1'b0;
        break;
      end
      if (host_gnt !== 1'b0) gnt_bad++;
      step();
    end
    checks++; if (to || gnt_bad !== 0) begin errors++; $display("FAIL tie_gnt_during_run: got timeout=%0b gnt_cycles=%0d want 0 0", to, gnt_bad); end
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL tie_gnt_after_run: got %0b want 1", host_gnt); end
    host_req = 1'b0;
    step();
  endtask

  task automatic test_max_epoch();
    bit to;
    load_ram();
    clear_log();
    dp_ready = 1'b1;
    w_in = {16{16'hFACE}};
    start_run(1, 255, 3, 4);
    wait_idle(2000, to);
    checks++; if (to) begin errors++; $display("FAIL max_timeout: got busy want idle"); end
    checks++; if (epoch_cnt !== 8'd255) begin errors++; $display("FAIL max_epoch_cnt: got %0d want 255", epoch_cnt); end
    checks++; if (rd_q.size() !== 256 || hs_data_q.size() !== 256) begin errors++; $display("FAIL max_counts: got rd=%0d hs=%0d want 256 256", rd_q.size(), hs_data_q.size()); end
    checks++; if (done_cnt !== 1 || wr_addr_q.size() !== 1 || wr_addr_q[0] !== AW'(2)) begin errors++; $display("FAIL max_wb_done: got done=%0d writes=%0d addr=%0d want 1 1 2", done_cnt, wr_addr_q.size(), wr_addr_q[0]); end
  endtask

  task automatic test_reset_mid();
    bit found, to;
    load_ram();
    clear_log();
    dp_ready = 1'b1;
    start_run(2, 2, 7, 5);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dp_valid && epoch_cnt == 8'd1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_epoch1: got no PRES in epoch 1 want it within 40 cycles"); end
    dp_ready = 1'b0;
    step(); step(); step();
    RST_N = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || dp_valid !== 1'b0 || ram_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy=%0b valid=%0b en=%0b done=%0b want 0 0 0 0", busy, dp_valid, ram_en, done); end
    checks++; if (epoch_cnt !== 8'd0 || cfg_feat !== 4'd0 || cfg_lr !== 4'd0 || dp_data !== '0) begin errors++; $display("FAIL rst_mid_regs: got epoch=%0d feat=%0d lr=%0d data=%0h want all 0", epoch_cnt, cfg_feat, cfg_lr, dp_data); end
    RST_N = 1'b1;
    load_ram();
    clear_log();
    dp_ready = 1'b1;
    start_run(2, 1, 1, 1);
    wait_idle(100, to);
    checks++; if (to) begin errors++; $display("FAIL rst_rerun_timeout: got busy want idle"); end
    checks++; if (rd_q.size() !== 3 || rd_q[0] !== AW'(0) || rd_q[2] !== AW'(2)) begin errors++; $display("FAIL rst_rerun_reads: got n=%0d first=%0d last=%0d want 3 0 2", rd_q.size(), rd_q[0], rd_q[2]); end
    checks++; if (hs_wload_q.size() !== 3 || hs_wload_q[0] !== 1'b1) begin errors++; $display("FAIL rst_rerun_wload: got n=%0d first=%0b want 3 1", hs_wload_q.size(), hs_wload_q[0]); end
    checks++; if (done_cnt !== 1 || wr_addr_q.size() !== 1 || wr_addr_q[0] !== AW'(3)) begin errors++; $display("FAIL rst_rerun_wb: got done=%0d writes=%0d addr=%0d want 1 1 3", done_cnt, wr_addr_q.size(), wr_addr_q[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_abort();
    test_host_vs_start();
    test_max_epoch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
